// File: rtl/fifo_mux_out.sv
// Synchronous FIFO that buffers words from an upstream mux for a downstream consumer.
// Read data is registered: one-cycle latency from an accepted pop to data_out/valid_out.
module fifo_mux_out #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AF_THR = 6,
  parameter int AE_THR = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       valid_in,
  input  logic                       pop,
  output logic [DATA_W-1:0]          data_out,
  output logic                       valid_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       error
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fill_count_q, fill_count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              error_q, error_d;

  logic wr_ok;
  logic rd_ok;
  logic err_evt;

  assign full         = (fill_count_q == CNT_W'(DEPTH));
  assign empty        = (fill_count_q == '0);
  assign almost_full  = (fill_count_q >= CNT_W'(AF_THR));
  assign almost_empty = (fill_count_q <= CNT_W'(AE_THR));

  // A pop frees a slot in the same cycle, so a write at full is allowed alongside it.
  assign rd_ok   = pop && !empty;
  assign wr_ok   = valid_in && (!full || pop);
  assign err_evt = (valid_in && full && !pop) || (pop && empty);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_count_d = fill_count_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    error_d      = error_q | err_evt;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_ok) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end

    case ({wr_ok, rd_ok})
      2'b10:   fill_count_d = fill_count_q + 1'b1;
      2'b01:   fill_count_d = fill_count_q - 1'b1;
      default: fill_count_d = fill_count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_count_q <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_count_q <= fill_count_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      error_q      <= error_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign fill_count = fill_count_q;
  assign error      = error_q;

endmodule

// File: tb/tb_fifo_mux_out.sv
// Self-checking bench for fifo_mux_out: vector table, corner-case sequences,
// and a queue scoreboard for interleaved traffic across pointer wrap-around.
module tb_fifo_mux_out;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] fill_count;
  logic       error;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_mux_out #(.DATA_W(8), .DEPTH(8), .AF_THR(6), .AE_THR(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_count   (fill_count),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vin;
    logic       pp;
    logic [7:0] din;
    int         cnt;
    logic       vout;
    logic [7:0] dout;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_flags(input string nm, input int cnt);
    chk({nm, " count"}, 32'(fill_count), 32'(cnt));
    chk({nm, " full"}, 32'(full), 32'(cnt == 8));
    chk({nm, " empty"}, 32'(empty), 32'(cnt == 0));
    chk({nm, " almost_full"}, 32'(almost_full), 32'(cnt >= 6));
    chk({nm, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
  endtask

  task automatic drive(input logic v, input logic p, input logic [7:0] d);
    valid_in = v;
    pop      = p;
    data_in  = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    pop      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] mq[$];
    logic [7:0] exq[$];
    logic [7:0] got;
    int wi, outs;
    logic v, p;

    // Basic push/pop, fill to full, overflow drop, drain in order.
    tbl.push_back('{1'b1, 1'b0, 8'hFF, 1, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'hEE, 2, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'hDD, 3, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 2, 1'b1, 8'hFF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'hEE, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hDD, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'hDD, 1'b0});
    for (int k = 0; k < 8; k++)
      tbl.push_back('{1'b1, 1'b0, 8'(k), k + 1, 1'b0, 8'hDD, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h08, 8, 1'b0, 8'hDD, 1'b1});
    for (int k = 0; k < 8; k++)
      tbl.push_back('{1'b0, 1'b1, 8'h00, 7 - k, 1'b1, 8'(k), 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h07, 1'b1});

    #2;
    chk_flags("reset", 0);
    chk("reset valid_out", 32'(valid_out), 32'd0);
    chk("reset data_out", 32'(data_out), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].vin, tbl[i].pp, tbl[i].din);
      chk($sformatf("vec%0d", i), 32'(fill_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d valid_out", i), 32'(valid_out), 32'(tbl[i].vout));
      chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(tbl[i].dout));
      chk($sformatf("vec%0d error", i), 32'(error), 32'(tbl[i].err));
      chk_flags($sformatf("vec%0d", i), tbl[i].cnt);
    end

    // Write with pop at full: oldest word out, count stays full, AA drains last.
    do_reset();
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 8'h30 + 8'(k));
    chk_flags("fill", 8);
    drive(1'b1, 1'b1, 8'hAA);
    chk("full rw valid_out", 32'(valid_out), 32'd1);
    chk("full rw data_out", 32'(data_out), 32'h30);
    chk_flags("full rw", 8);
    chk("full rw error", 32'(error), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 8'h00);
      chk("drain data_out", 32'(data_out), (k == 7) ? 32'hAA : 32'h31 + 32'(k));
    end
    chk_flags("drained", 0);

    // Pop on empty with simultaneous push: no fall-through, error set.
    do_reset();
    drive(1'b1, 1'b1, 8'h55);
    chk("empty rw valid_out", 32'(valid_out), 32'd0);
    chk("empty rw count", 32'(fill_count), 32'd1);
    chk("empty rw error", 32'(error), 32'd1);
    drive(1'b0, 1'b1, 8'h00);
    chk("empty rw pop valid", 32'(valid_out), 32'd1);
    chk("empty rw pop data", 32'(data_out), 32'h55);

    // Pop on empty with no push.
    do_reset();
    drive(1'b0, 1'b1, 8'h00);
    chk("underflow valid_out", 32'(valid_out), 32'd0);
    chk("underflow count", 32'(fill_count), 32'd0);
    chk("underflow error", 32'(error), 32'd1);

    // Interleaved traffic across wrap-around, checked through a scoreboard.
    do_reset();
    wi = 0;
    outs = 0;
    for (int cyc = 0; cyc < 200 && outs < 20; cyc++) begin
      v = (wi < 20) && ($urandom_range(0, 3) != 0);
      p = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      if (v && !p && mq.size() == 8) p = 1'b1;
      if (p) exq.push_back(mq.pop_front());
      if (v) begin
        mq.push_back(8'h10 + 8'(wi));
        wi++;
      end
      drive(v, p, v ? 8'h10 + 8'(wi - 1) : 8'h00);
      if (valid_out) begin
        if (exq.size() == 0) begin
          chk("sb unexpected valid_out", 32'd1, 32'd0);
        end else begin
          got = exq.pop_front();
          chk("sb data_out", 32'(data_out), 32'(got));
          outs++;
        end
      end
      chk("sb count", 32'(fill_count), 32'(mq.size()));
      chk("sb count range", 32'(fill_count <= 4'd8), 32'd1);
    end
    chk("sb words out", 32'(outs), 32'd20);
    chk("sb error", 32'(error), 32'd0);

    // Asynchronous reset with 5 stored words and a live valid_out.
    do_reset();
    drive(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, 8'h60 + 8'(k));
    drive(1'b0, 1'b1, 8'h00);
    chk("pre-reset count", 32'(fill_count), 32'd5);
    chk("pre-reset valid_out", 32'(valid_out), 32'd1);
    chk("pre-reset error", 32'(error), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_flags("async reset", 0);
    chk("async reset valid_out", 32'(valid_out), 32'd0);
    chk("async reset error", 32'(error), 32'd0);
    chk("async reset data_out", 32'(data_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'h77);
    chk("post-reset count", 32'(fill_count), 32'd1);
    drive(1'b0, 1'b1, 8'h00);
    chk("post-reset valid_out", 32'(valid_out), 32'd1);
    chk("post-reset data_out", 32'(data_out), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
